// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, sequences redirect/exception flushes, buffers one redirect.
// Latency: stall is combinational; flush/new_pc/new_pc_valid appear one cycle after the accepting edge.
// Backpressure: a redirect blocked by ex/mem stalls is parked; optional watchdog under PIPE_CTRL_WDOG_EN.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_LIMIT   = 255,
  parameter int WDOG_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        redirect_req,
  input  logic [31:0] redirect_pc,
  input  logic        excp_req,
  input  logic [31:0] excp_pc,
  output logic [5:0]  stall,
  output logic [5:0]  flush,
  output logic        new_pc_valid,
  output logic [31:0] new_pc,
  output logic        busy,
  output logic        stall_timeout
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FCNT_INIT = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [FCW-1:0]  cnt_q, cnt_d;
  logic            pend_v_q, pend_v_d;
  logic [31:0]     pend_pc_q, pend_pc_d;
  logic [5:0]      flush_q, flush_d;
  logic            npv_q, npv_d;
  logic [31:0]     new_pc_q, new_pc_d;

  logic [5:0]      stall_req;
  logic            redir_live;
  logic [31:0]     redir_pc;
  logic            back_stall;

  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem)      stall_req = 6'b011111;
    else if (stallreq_ex)  stall_req = 6'b001111;
    else if (stallreq_id)  stall_req = 6'b000111;
  end

  // Stall is suppressed while reset is asserted so outputs read zero throughout reset.
  assign stall = (rst && (state_q == RUN) && !excp_req) ? stall_req : 6'b000000;

  assign redir_live = redirect_req || pend_v_q;
  assign redir_pc   = redirect_req ? redirect_pc : pend_pc_q;
  assign back_stall = stallreq_ex || stallreq_mem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    flush_d   = flush_q;
    npv_d     = 1'b0;
    new_pc_d  = new_pc_q;
    if (excp_req) begin
      state_d  = FLUSH;
      cnt_d    = FCNT_INIT;
      flush_d  = 6'b011110;
      npv_d    = 1'b1;
      new_pc_d = excp_pc;
      pend_v_d = 1'b0;
    end else if (state_q == FLUSH) begin
      // Redirects seen here come from squashed instructions and are dropped.
      if (cnt_q == '0) begin
        state_d = RUN;
        flush_d = 6'b000000;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (redir_live) begin
      if (back_stall) begin
        pend_v_d  = 1'b1;
        pend_pc_d = redir_pc;
      end else begin
        state_d  = FLUSH;
        cnt_d    = FCNT_INIT;
        flush_d  = 6'b000110;
        npv_d    = 1'b1;
        new_pc_d = redir_pc;
        pend_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      pend_v_q  <= 1'b0;
      pend_pc_q <= 32'h0;
      flush_q   <= 6'b000000;
      npv_q     <= 1'b0;
      new_pc_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
      flush_q   <= flush_d;
      npv_q     <= npv_d;
      new_pc_q  <= new_pc_d;
    end
  end

  assign flush        = flush_q;
  assign new_pc_valid = npv_q;
  assign new_pc       = new_pc_q;
  assign busy         = (state_q == FLUSH) || pend_v_q;

`ifdef PIPE_CTRL_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_LIMIT);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q | (wdog_q == WDOG_LIM);
    if (stall == 6'b000000)    wdog_d = '0;
    else if (wdog_q != WDOG_LIM) wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_timeout = timeout_q;
`else
  logic unused_wdog;
  assign unused_wdog   = ^{WDOG_LIMIT, WDOG_W};
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed table bench for pipe_ctrl plus a hand-written watchdog sequence.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        redirect_req, excp_req;
  logic [31:0] redirect_pc, excp_pc;
  logic [5:0]  stall, flush;
  logic        new_pc_valid, busy, stall_timeout;
  logic [31:0] new_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(1), .WDOG_LIMIT(4), .WDOG_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .redirect_req (redirect_req),
    .redirect_pc  (redirect_pc),
    .excp_req     (excp_req),
    .excp_pc      (excp_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc_valid (new_pc_valid),
    .new_pc       (new_pc),
    .busy         (busy),
    .stall_timeout(stall_timeout)
  );

  typedef struct {
    logic        r, id, ex, mem, rr, er;
    logic [31:0] rpc, epc;
    logic [5:0]  e_stall, e_flush;
    logic        e_npv;
    logic [31:0] e_npc;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, id, ex, mem, rr, input logic [31:0] rpc,
                              input logic er, input logic [31:0] epc,
                              input logic [5:0] s, f, input logic npv,
                              input logic [31:0] npc, input logic b);
    vec_t v;
    v.r = r; v.id = id; v.ex = ex; v.mem = mem; v.rr = rr; v.rpc = rpc;
    v.er = er; v.epc = epc;
    v.e_stall = s; v.e_flush = f; v.e_npv = npv; v.e_npc = npc; v.e_busy = b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.r; stallreq_id = v.id; stallreq_ex = v.ex; stallreq_mem = v.mem;
    redirect_req = v.rr; redirect_pc = v.rpc; excp_req = v.er; excp_pc = v.epc;
  endtask

  initial begin
    logic wd_en;
`ifdef PIPE_CTRL_WDOG_EN
    wd_en = 1'b1;
`else
    wd_en = 1'b0;
`endif
    //          r  id ex mm rr rpc           er epc          stall      flush      npv npc           busy
    vq.push_back(mk(0, 1, 0, 1, 1, 32'h55,  0, 32'h0,  6'b000000, 6'b000000, 0, 32'h0,   0)); // 0 reset
    vq.push_back(mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h66, 6'b000000, 6'b000000, 0, 32'h0,   0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h0,   0));
    vq.push_back(mk(1, 1, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000111, 6'b000000, 0, 32'h0,   0)); // 3 stall enc
    vq.push_back(mk(1, 1, 0, 1, 0, 32'h0,   0, 32'h0,  6'b011111, 6'b000000, 0, 32'h0,   0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h0,   0));
    vq.push_back(mk(1, 0, 0, 0, 1, 32'h100, 0, 32'h0,  6'b000000, 6'b000000, 0, 32'h0,   0)); // 6 redirect
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000110, 1, 32'h100, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h100, 0));
    vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,   0, 32'h0,  6'b001111, 6'b000000, 0, 32'h100, 0)); // 9 pending
    vq.push_back(mk(1, 0, 1, 0, 1, 32'h200, 0, 32'h0,  6'b001111, 6'b000000, 0, 32'h100, 0));
    vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,   0, 32'h0,  6'b001111, 6'b000000, 0, 32'h100, 1));
    vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,   0, 32'h0,  6'b001111, 6'b000000, 0, 32'h100, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h100, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000110, 1, 32'h200, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h200, 0));
    vq.push_back(mk(1, 0, 0, 1, 0, 32'h0,   0, 32'h0,  6'b011111, 6'b000000, 0, 32'h200, 0)); // 16 collision
    vq.push_back(mk(1, 0, 0, 1, 1, 32'h300, 1, 32'h80, 6'b000000, 6'b000000, 0, 32'h200, 0));
    vq.push_back(mk(1, 0, 0, 1, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b011110, 1, 32'h80,  1));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h80,  0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h80,  0));
    vq.push_back(mk(1, 0, 0, 0, 1, 32'h400, 0, 32'h0,  6'b000000, 6'b000000, 0, 32'h80,  0)); // 21 redir in FLUSH
    vq.push_back(mk(1, 1, 0, 0, 1, 32'h500, 0, 32'h0,  6'b000000, 6'b000110, 1, 32'h400, 1));
    vq.push_back(mk(1, 1, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000111, 6'b000000, 0, 32'h400, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h400, 0));
    vq.push_back(mk(1, 0, 0, 1, 1, 32'h600, 0, 32'h0,  6'b011111, 6'b000000, 0, 32'h400, 0)); // 25 overwrite
    vq.push_back(mk(1, 0, 0, 1, 1, 32'h700, 0, 32'h0,  6'b011111, 6'b000000, 0, 32'h400, 1));
    vq.push_back(mk(1, 1, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000111, 6'b000000, 0, 32'h400, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000110, 1, 32'h700, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h700, 0));
    vq.push_back(mk(1, 0, 1, 0, 1, 32'h800, 0, 32'h0,  6'b001111, 6'b000000, 0, 32'h700, 0)); // 30 excp drops pend
    vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,   1, 32'h90, 6'b000000, 6'b000000, 0, 32'h700, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b011110, 1, 32'h90,  1));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h90,  0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h90,  0));
    vq.push_back(mk(1, 0, 1, 0, 1, 32'hA00, 0, 32'h0,  6'b001111, 6'b000000, 0, 32'h90,  0)); // 35 reset w/ pend
    vq.push_back(mk(0, 0, 1, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h90,  1));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h0,   0));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,  6'b000000, 6'b000000, 0, 32'h0,   0));

    // Reset held with inputs active before the table starts.
    drive(mk(0, 1, 1, 1, 1, 32'h11, 1, 32'h22, 6'b0, 6'b0, 0, 32'h0, 0));
    @(posedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      #1 drive(vq[i]);
      @(negedge clk);
      chk($sformatf("v%0d.stall", i), {26'h0, stall}, {26'h0, vq[i].e_stall});
      chk($sformatf("v%0d.flush", i), {26'h0, flush}, {26'h0, vq[i].e_flush});
      chk($sformatf("v%0d.npv", i),   {31'h0, new_pc_valid}, {31'h0, vq[i].e_npv});
      chk($sformatf("v%0d.new_pc", i), new_pc, vq[i].e_npc);
      chk($sformatf("v%0d.busy", i),  {31'h0, busy}, {31'h0, vq[i].e_busy});
      @(posedge clk);
    end

    // Watchdog: reset, then hold a mem stall and watch the sticky flag.
    #1 drive(mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 6'b0, 6'b0, 0, 32'h0, 0));
    @(posedge clk);
    #1 rst = 1'b1; stallreq_mem = 1'b1;
    @(negedge clk);
    chk("wd.after_rst", {31'h0, stall_timeout}, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("wd.hold%0d", i), {31'h0, stall_timeout}, {31'h0, wd_en && (i >= 5)});
    end
    stallreq_mem = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("wd.released%0d", i), {31'h0, stall_timeout}, {31'h0, wd_en});
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("wd.cleared", {31'h0, stall_timeout}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("wd.idle", {31'h0, stall_timeout}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
